// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port among NREQ sources, registering the winner.
// Round-robin by default; define RF_WB_FIXED_PRIO_EN for fixed priority (source 0 highest).
module rf_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           i_req_valid,
  output logic [NREQ-1:0]           o_req_ready,
  input  logic [NREQ*ADDR_W-1:0]    i_req_rd,
  input  logic [NREQ*DATA_W-1:0]    i_req_data,
  output logic                      o_rf_reg_write,
  output logic [ADDR_W-1:0]         o_rf_rd,
  output logic [DATA_W-1:0]         o_rf_write_data,
  output logic [$clog2(NREQ)-1:0]   o_grant_id,
  output logic                      o_pending
);

  localparam int IDX_W = $clog2(NREQ);

  // Handshake: source i transfers in a cycle where i_req_valid[i] & o_req_ready[i];
  // a source holds valid/rd/data stable until accepted, and at most one source is
  // ready per cycle. o_req_ready depends combinationally on i_req_valid.

  logic [IDX_W-1:0]  w_win;
  logic              w_found;
  logic [NREQ-1:0]   w_ready;
  logic [NREQ-1:0]   w_xfer_mask;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_we;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic [IDX_W-1:0]  r_gid;

`ifdef RF_WB_FIXED_PRIO_EN
  // Scan from lowest priority upward so the last hit is the highest-priority source.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        w_found = 1'b1;
        w_win   = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] r_lp;

  // Search order is lp+1, lp+2, ... wrapping; scanned in reverse so the last hit wins.
  always_comb begin
    logic [IDX_W-1:0] w_idx;
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(r_lp) + k) % NREQ);
      if (i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lp <= IDX_W'(NREQ - 1);
    end else if (w_xfer) begin
      r_lp <= w_win;
    end
  end
`endif

  always_comb begin
    w_ready = '0;
    if (w_found && !reset) begin
      w_ready = NREQ'(1) << w_win;
    end
  end

  assign w_xfer_mask = i_req_valid & w_ready;
  assign w_xfer      = |w_xfer_mask;
  assign w_sel_rd    = i_req_rd[w_win*ADDR_W +: ADDR_W];
  assign w_sel_data  = i_req_data[w_win*DATA_W +: DATA_W];

  // r0 writes are accepted (pointer advances) but never assert the write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
      r_gid  <= '0;
    end else begin
      r_we <= w_xfer && (w_sel_rd != '0);
      if (w_xfer) begin
        r_rd   <= w_sel_rd;
        r_data <= w_sel_data;
        r_gid  <= w_win;
      end
    end
  end

  assign o_req_ready     = w_ready;
  assign o_pending       = |(i_req_valid & ~w_xfer_mask);
  assign o_rf_reg_write  = r_we;
  assign o_rf_rd         = r_rd;
  assign o_rf_write_data = r_data;
  assign o_grant_id      = r_gid;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port among NREQ writeback sources: ALU, load unit and mult/div unit.
- Round-robin arbitration with a valid/ready handshake per source.
- The winning request is registered and presented to the register file write port (reg_write/rd/write_data) one cycle later.
- Sits between the execute/memory stages and the register file; the pipeline controller observes busy/pending state for hazard stalls.

Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- DATA_W, 32, write data width
- ADDR_W, 5, register index width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  NREQ  per-source write request
- req_ready  output  NREQ  per-source grant/accept (combinational)
- req_rd  input  NREQ*ADDR_W  per-source destination index, source i at bits [i*ADDR_W +: ADDR_W]
- req_data  input  NREQ*DATA_W  per-source write data, same packing
- rf_reg_write  output  1  to register file reg_write
- rf_rd  output  ADDR_W  to register file rd
- rf_write_data  output  DATA_W  to register file write_data
- grant_id  output  $clog2(NREQ)  index of source whose write is on rf_* this cycle
- pending  output  1  high when any req_valid is not accepted this cycle (backpressure indicator)

Behaviour:
- Reset (async, active-high) values:
  - rf_reg_write=0, rf_rd=0, rf_write_data=0, grant_id=0
  - last-grant pointer lp=NREQ-1, so source 0 has top priority first
  - req_ready=0 while reset asserted
- Arbitration (combinational, each cycle):
  - Search order starts at lp+1 and wraps modulo NREQ.
  - The first source with req_valid=1 wins; only that source gets req_ready=1.
  - If no source is valid, req_ready is all zero.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - A source must hold valid/rd/data stable until accepted; it must not deassert valid before ready.
  - At most one transfer per cycle.
- Pointer: lp updates to the winner index on a transfer only; idle cycles leave lp unchanged.
- Output register (1-cycle latency): on the clk edge after a transfer:
  - rf_rd <= req_rd[i], rf_write_data <= req_data[i], grant_id <= i
  - rf_reg_write <= (req_rd[i] != 0)
- With no transfer, rf_reg_write <= 0; rf_rd, rf_write_data and grant_id hold their last values.
- rd==0: the request is still accepted and lp advances, but rf_reg_write stays 0. r0 writes are discarded here and never reach the register file.
- pending = |req_valid & ~(transfer mask). Combinational; used by the hazard unit to stall issue.
- Back-to-back: a source with continuous valid is granted at most once every NREQ cycles when all sources are valid (fairness bound NREQ-1 waiting cycles).
- Reset mid-operation:
  - Any in-flight registered write is dropped; rf_reg_write forced to 0 immediately (async).
  - Sources see no acceptance and must re-present after reset.
- Same rd from two sources in consecutive cycles: both writes are issued in grant order; the later grant wins in the register file. The arbiter does not reorder.

Optional Feature:
- Macro: RF_WB_FIXED_PRIO_EN
- Defined: fixed priority, source 0 highest, then 1, ... NREQ-1. lp is not implemented; the fairness bound does not apply.
- Undefined (default): round-robin as above.
- Handshake, latency, rd==0 handling and reset behaviour are identical in both builds.

Test Plan:
- Reset with all valid=0 -> rf_reg_write=0, req_ready=000, grant_id=0, pending=0.
- Single request: src1 valid, rd=5, data=0xDEADBEEF -> req_ready=010 same cycle; next cycle rf_reg_write=1, rf_rd=5, rf_write_data=0xDEADBEEF, grant_id=1; following cycle rf_reg_write=0.
- All three sources valid for 6 cycles (rd=1,2,3) -> grant order 0,1,2,0,1,2 and rf_rd 1,2,3,1,2,3; pending=1 every cycle. With RF_WB_FIXED_PRIO_EN: grant 0 every cycle, pending=1.
- src2 valid with rd=0, data=0x1234 -> accepted (req_ready=100), next cycle rf_reg_write=0, lp=2; a subsequent src0 request is granted next.
- Async reset asserted mid-cycle after a transfer, before the output edge -> rf_reg_write=0 immediately, lp=NREQ-1; after release, src0 and src2 valid -> src0 granted first.
